// File: rtl/clken_pkg.sv
// Shared types and sizing helpers for the clock-enable generator.
package clken_pkg;

    // Lock-qualification FSM states.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        COUNT     = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Number of flops in the locked_in synchroniser.
    localparam int SYNC_DEPTH = 2;

    // Width of the lock counter. It holds values up to lock_cycles-1.
    function automatic int cnt_width(input int lock_cycles);
        return (lock_cycles < 2) ? 1 : $clog2(lock_cycles);
    endfunction

endpackage

// File: rtl/clken_phase_acc.sv
// One channel of the clock-enable generator: phase accumulator, carry-to-ce
// register and, with CLKEN_TOGGLE_OUT_EN, a toggle flop for pins/probes.
module clken_phase_acc
    import clken_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             run,
    input  logic             phase_sync,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             ce
`ifdef CLKEN_TOGGLE_OUT_EN
    ,
    output logic             tog
`endif
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // The add is one bit wider than the accumulator; the top bit is the wrap.
    assign sum = {1'b0, acc} + {1'b0, inc};

    // Accumulate while running. Reset, not-RUN, phase_sync and channel disable
    // all collapse to the same clear, so their relative priority is moot here.
    always_ff @(posedge clkin) begin
        if (rst || !run || phase_sync || !en) begin
            acc <= '0;
            ce  <= 1'b0;
        end else begin
            acc <= sum[ACC_W-1:0];
            ce  <= sum[ACC_W];
        end
    end

`ifdef CLKEN_TOGGLE_OUT_EN
    // Flip on the same edge that raises ce, so tog changes once per strobe.
    always_ff @(posedge clkin) begin
        if (rst || !run || phase_sync || !en) begin
            tog <= 1'b0;
        end else begin
            tog <= tog ^ sum[ACC_W];
        end
    end
`endif

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator.
// Holds the locked_in synchroniser, the lock-qualification FSM and its
// counter, and instantiates one clken_phase_acc per channel.
// Optional macro CLKEN_TOGGLE_OUT_EN adds the per-channel tog output.
module clken_gen
    import clken_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                      clkin,
    input  logic                      rst,
    input  logic                      locked_in,
    input  logic [CHANNELS*ACC_W-1:0] inc,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic                      phase_sync,
    output logic [CHANNELS-1:0]       ce,
    output logic                      ready
`ifdef CLKEN_TOGGLE_OUT_EN
    ,
    output logic [CHANNELS-1:0]       tog
`endif
);

    localparam int             CW       = cnt_width(LOCK_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(LOCK_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  locked_s;
    state_t                state, next_state;
    logic [CW-1:0]         cnt, cnt_next;
    logic                  run;

    // Bring the asynchronous PLL lock into the clkin domain.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], locked_in};
        end
    end

    assign locked_s = sync_q[SYNC_DEPTH-1];

    // State, lock counter and ready registers. ready is loaded from the next
    // state so it always equals (state == RUN).
    always_ff @(posedge clkin) begin
        if (rst) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            ready <= (next_state == RUN);
        end
    end

    // Next-state logic. The counter holds the number of consecutive
    // synced-lock cycles seen so far; the first one is counted on the way
    // out of WAIT_LOCK, so RUN is entered after exactly LOCK_CYCLES of them.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            WAIT_LOCK: begin
                cnt_next = '0;
                if (locked_s) begin
                    next_state = COUNT;
                    cnt_next   = CW'(1);
                end
            end
            COUNT: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end
            end
            default: begin
                next_state = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Accumulate only while RUN persists. Gating on next_state as well lets the
    // channels clear on the same edge that leaves RUN, so ce drops with ready.
    assign run = (state == RUN) && (next_state == RUN);

    // One phase accumulator per channel.
    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        clken_phase_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .clkin      (clkin),
            .rst        (rst),
            .run        (run),
            .phase_sync (phase_sync),
            .en         (ch_en[n]),
            .inc        (inc[n*ACC_W +: ACC_W]),
            .ce         (ce[n])
`ifdef CLKEN_TOGGLE_OUT_EN
            ,
            .tog        (tog[n])
`endif
        );
    end

endmodule

// File: tb/tb_clken_gen.sv
// Directed self-checking bench for clken_gen (CHANNELS=4, ACC_W=32,
// LOCK_CYCLES=16). Inputs change 1 time unit after each rising edge and
// outputs are sampled at that same point.
module tb_clken_gen;

    localparam int CH = 4;
    localparam int AW = 32;
    localparam int LC = 16;

    logic              clkin = 1'b0;
    logic              rst;
    logic              locked_in;
    logic [CH*AW-1:0]  inc;
    logic [CH-1:0]     ch_en;
    logic              phase_sync;
    logic [CH-1:0]     ce;
    logic              ready;
`ifdef CLKEN_TOGGLE_OUT_EN
    logic [CH-1:0]     tog;
`endif

    int checks   = 0;
    int failures = 0;

    clken_gen #(
        .CHANNELS    (CH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LC)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .locked_in  (locked_in),
        .inc        (inc),
        .ch_en      (ch_en),
        .phase_sync (phase_sync),
        .ce         (ce),
        .ready      (ready)
`ifdef CLKEN_TOGGLE_OUT_EN
        ,
        .tog        (tog)
`endif
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int first0, first1, n0, n1, n2, n3, last3, badsp, togbad;
        logic prev_tog0;

        rst        = 1'b1;
        locked_in  = 1'b0;
        inc        = '0;
        ch_en      = '0;
        phase_sync = 1'b0;
        tick();
        tick();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_ce", {28'd0, ce}, 32'd0);
`ifdef CLKEN_TOGGLE_OUT_EN
        chk("reset_tog", {28'd0, tog}, 32'd0);
`endif

        // Channel setup used by the rate checks once RUN is reached.
        rst = 1'b0;
        inc[0*AW +: AW] = 32'h4000_0000;
        inc[1*AW +: AW] = 32'h8000_0000;
        inc[2*AW +: AW] = 32'h0000_0000;
        inc[3*AW +: AW] = 32'h5555_5555;
        ch_en = 4'hF;

        // Lock glitch: high 10 cycles, low 1, then high for good.
        locked_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("glitch_pre_ready", {31'd0, ready}, 32'd0);
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("lock_wait_ce", {28'd0, ce}, 32'd0);
        end
        chk("lock_edge17_ready", {31'd0, ready}, 32'd0);
        tick();
        chk("lock_edge18_ready", {31'd0, ready}, 32'd1);

        // Now in RUN cycle 1. ce seen in cycle k reflects the add at the end
        // of cycle k-1, so cycles 2..65 cover exactly 64 adds.
        first0 = 0; first1 = 0; n0 = 0; n1 = 0; n2 = 0; n3 = 0;
        last3 = 0; badsp = 0; togbad = 0; prev_tog0 = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            if (ce[0] && first0 == 0) first0 = k;
            if (ce[1] && first1 == 0) first1 = k;
            if (k >= 2 && k <= 65) begin
                n0 += int'(ce[0]);
                n1 += int'(ce[1]);
                n2 += int'(ce[2]);
            end
            if (ce[3]) begin
                n3++;
                if (last3 != 0 && (k - last3 < 2 || k - last3 > 3)) badsp++;
                last3 = k;
            end
`ifdef CLKEN_TOGGLE_OUT_EN
            if (tog[0] !== (prev_tog0 ^ ce[0])) togbad++;
            prev_tog0 = tog[0];
`endif
            tick();
        end
        chk("ch0_first_pulse_cycle", first0, 5);
        chk("ch1_first_pulse_cycle", first1, 3);
        chk("ch0_pulses_64", n0, 16);
        chk("ch1_pulses_64", n1, 32);
        chk("ch2_pulses_64", n2, 0);
        chk("ch3_count_in_999_1001", {31'd0, (n3 >= 999 && n3 <= 1001)}, 32'd1);
        chk("ch3_spacing_violations", badsp, 0);
`ifdef CLKEN_TOGGLE_OUT_EN
        chk("tog0_follows_ce0", togbad, 0);
`endif

        // Max increment: first add no carry, every later add carries.
        inc[2*AW +: AW] = 32'hFFFF_FFFF;
        tick();
        chk("ch2_max_first", {31'd0, ce[2]}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ch2_max_run", {31'd0, ce[2]}, 32'd1);
        end

        // Channel disable clears phase; re-enable restarts from 0.
        ch_en[1] = 1'b0;
        tick();
        chk("ch1_disabled_ce", {31'd0, ce[1]}, 32'd0);
        ch_en[1] = 1'b1;
        tick();
        chk("ch1_reen_add1", {31'd0, ce[1]}, 32'd0);
        tick();
        chk("ch1_reen_add2", {31'd0, ce[1]}, 32'd1);
        tick();
        chk("ch1_reen_add3", {31'd0, ce[1]}, 32'd0);

        // phase_sync aligns ch0 and ch3, then a second sync lands on the
        // edge where ch0 would wrap and suppresses that strobe.
        inc[3*AW +: AW] = 32'h4000_0000;
        phase_sync = 1'b1;
        tick();
        chk("psync_all_ce", {28'd0, ce}, 32'd0);
        phase_sync = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        phase_sync = 1'b1;
        tick();
        chk("psync_suppress_ce0", {31'd0, ce[0]}, 32'd0);
        phase_sync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("psync_gap_ce03", {30'd0, ce[3], ce[0]}, 32'd0);
        end
        tick();
        chk("psync_coincident_1", {30'd0, ce[3], ce[0]}, 32'd3);
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("psync_coincident_2", {30'd0, ce[3], ce[0]}, 32'd3);

        // Lock loss in RUN: ready and ce drop on the third edge.
        locked_in = 1'b0;
        tick();
        tick();
        chk("lockloss_edge2_ready", {31'd0, ready}, 32'd1);
        tick();
        chk("lockloss_edge3_ready", {31'd0, ready}, 32'd0);
        chk("lockloss_edge3_ce", {28'd0, ce}, 32'd0);
`ifdef CLKEN_TOGGLE_OUT_EN
        chk("lockloss_tog", {28'd0, tog}, 32'd0);
`endif
        locked_in = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("relock_edge17_ready", {31'd0, ready}, 32'd0);
        chk("relock_edge17_ce", {28'd0, ce}, 32'd0);
        tick();
        chk("relock_edge18_ready", {31'd0, ready}, 32'd1);

        // Reset mid-operation forces a full requalification.
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_ce", {28'd0, ce}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("postrst_edge17_ready", {31'd0, ready}, 32'd0);
        tick();
        chk("postrst_edge18_ready", {31'd0, ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
